// File: rtl/zero_check_pipe_if.sv
// zero_check_pipe_if: valid/ready handshake and result bundle for zero_check_pipe
//   master: producer/consumer side (drives in_valid, a, mode, out_ready)
//   slave : zero_check_pipe side (drives in_ready and all results)
interface zero_check_pipe_if #(
  parameter int N      = 32,
  parameter int LANE_W = 8
);
  localparam int LANES = N / LANE_W;
  localparam int IDX_W = LANES > 1 ? $clog2(LANES) : 1;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     a;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic             zero;
  logic             nzero;
  logic [LANES-1:0] lane_zero;
  logic [IDX_W-1:0] first_nz;
  logic             first_nz_valid;
  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, zero, nzero, lane_zero, first_nz, first_nz_valid
  );
  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, zero, nzero, lane_zero, first_nz, first_nz_valid
  );
endinterface

// File: rtl/zero_check_pipe.sv
// zero_check_pipe: two-stage pipelined lane-wise zero / all-ones test with valid/ready
//   clk, reset (sync, active-high); bus: zero_check_pipe_if.slave
//   optional ZERO_CHECK_STICKY_EN adds sticky_clr (in) and sticky_nz (out)
module zero_check_pipe #(
  parameter int N      = 32,
  parameter int LANE_W = 8
) (
  input logic               clk,
  input logic               reset,
  zero_check_pipe_if.slave  bus
`ifdef ZERO_CHECK_STICKY_EN
  ,
  input  logic              sticky_clr,
  output logic              sticky_nz
`endif
);
  localparam int LANES = N / LANE_W;
  localparam int IDX_W = LANES > 1 ? $clog2(LANES) : 1;
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [LANES-1:0] lane_or_q, lane_or_d, lane_or_in;
  logic [LANES-1:0] lane_zero_q, lane_zero_d;
  logic             zero_q, zero_d, nzero_q, nzero_d;
  logic [IDX_W-1:0] first_nz_q, first_nz_d, first_idx;
  logic [N-1:0]     b;
  logic             s2_adv, accept;
  always_comb begin
    s2_adv     = s1_valid_q && (!s2_valid_q || bus.out_ready);
    accept     = bus.in_valid && (!s1_valid_q || s2_adv);
    b          = bus.mode ? ~bus.a : bus.a;
    lane_or_in = '0;
    for (int k = 0; k < LANES; k++) lane_or_in[k] = |b[k*LANE_W +: LANE_W];
    // descending scan so the lowest set lane is the last to write
    first_idx  = '0;
    for (int k = LANES - 1; k >= 0; k--) if (lane_or_q[k]) first_idx = IDX_W'(k);
    s1_valid_d  = accept ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
    lane_or_d   = accept ? lane_or_in : lane_or_q;
    s2_valid_d  = s2_adv ? 1'b1 : (bus.out_ready ? 1'b0 : s2_valid_q);
    lane_zero_d = s2_adv ? ~lane_or_q : lane_zero_q;
    zero_d      = s2_adv ? ~|lane_or_q : zero_q;
    nzero_d     = s2_adv ? |lane_or_q : nzero_q;
    first_nz_d  = s2_adv ? first_idx : first_nz_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      lane_or_q   <= '0;
      lane_zero_q <= '1;
      zero_q      <= 1'b1;
      nzero_q     <= 1'b0;
      first_nz_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      lane_or_q   <= lane_or_d;
      lane_zero_q <= lane_zero_d;
      zero_q      <= zero_d;
      nzero_q     <= nzero_d;
      first_nz_q  <= first_nz_d;
    end
  end
  assign bus.in_ready       = !s1_valid_q || s2_adv;
  assign bus.out_valid      = s2_valid_q;
  assign bus.zero           = zero_q;
  assign bus.nzero          = nzero_q;
  assign bus.lane_zero      = lane_zero_q;
  assign bus.first_nz       = first_nz_q;
  assign bus.first_nz_valid = nzero_q;
`ifdef ZERO_CHECK_STICKY_EN
  logic sticky_nz_q, sticky_nz_d;
  // a set in the same cycle as a clear wins
  always_comb sticky_nz_d = (s2_valid_q && bus.out_ready && nzero_q) || (sticky_nz_q && !sticky_clr);
  always_ff @(posedge clk) begin
    if (reset) sticky_nz_q <= 1'b0;
    else sticky_nz_q <= sticky_nz_d;
  end
  assign sticky_nz = sticky_nz_q;
`endif
endmodule

// File: doc/zero_check_pipe.md
Name: zero_check_pipe

Overview:
- Pipelined, parametrised successor to the combinational zero_check.
- Tests an N-bit word split into LANES lanes of LANE_W bits, in either zero-test or all-ones-test mode.
- Reports whole-word zero/nzero, per-lane zero flags and the index of the lowest non-zero lane.
- Two registered stages with valid/ready handshake; sits between the ALU/compare path and the branch-resolution/flag logic.

Parameters:
- N, 32, word width; must be a multiple of LANE_W.
- LANE_W, 8, lane width in bits; LANES = N/LANE_W (localparam), IDX_W = max(1, clog2(LANES)) (localparam).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- a  input  N  word under test.
- mode  input  1  0 = test for all-zero; 1 = test for all-ones (a is inverted before testing).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- zero  output  1  every lane tested zero.
- nzero  output  1  inverse of zero.
- lane_zero  output  LANES  bit k = 1 when lane k (a[k*LANE_W +: LANE_W]) tested zero.
- first_nz  output  IDX_W  index of the lowest-numbered non-zero lane; 0 when zero=1.
- first_nz_valid  output  1  equals nzero.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset; it is sampled only on the rising clk edge.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, zero=1, nzero=0, lane_zero all 1, first_nz=0, first_nz_valid=0.
- Stage 1, on accept (in_valid && in_ready): b = mode ? ~a : a; register per-lane OR of b (LANES bits) and set s1_valid.
- Stage 2: from the stage-1 register, compute lane_zero = ~lane_or, zero = ~|lane_or, nzero = |lane_or, first_nz = lowest set index of lane_or (0 if none); register these and set s2_valid. out_valid = s2_valid.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_adv (combinational from registered state and out_ready; no path from in_valid).
  - Stage 1 loads on accept; it clears s1_valid when s2_adv happens without a new accept.
  - s2_valid clears on out_ready && s2_valid when there is no s2_adv.
- Latency: exactly 2 cycles from accept to out_valid when out_ready stays high. Throughput: 1 word/cycle.
- Stall: while out_valid && !out_ready, all outputs hold stable. Stage 1 may still fill once, then in_ready=0. No data is lost or duplicated.
- Simultaneous consume and accept in a full pipe: both stages advance in the same cycle and in_ready stays 1.
- Output data registers keep their last value when out_valid=0; consumers must qualify them with out_valid.
- Reset mid-operation: in-flight words are discarded and all outputs return to their reset values on the next edge.
- LANES=1: first_nz is always 0 and lane_zero[0]=zero.

Optional Feature:
- Macro: ZERO_CHECK_STICKY_EN.
- With the macro defined:
  - Extra ports: sticky_clr (input, 1) and sticky_nz (output, 1, reset 0).
  - sticky_nz is set on any cycle where out_valid && out_ready && nzero.
  - sticky_clr clears sticky_nz; if clear and set happen in the same cycle, set wins, so the result is 1.
- Without the macro: the ports and the register do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then a=0, mode=0, single accept with out_ready=1 -> out_valid rises exactly 2 cycles later with zero=1, nzero=0, lane_zero=4'b1111, first_nz=0, first_nz_valid=0.
- Walking one, i=0..31: a=1<<i, mode=0 -> zero=0, nzero=1, lane_zero has bit (i/8) cleared, first_nz=i/8. Then a=0 -> zero=1.
- mode=1 with a=32'hFFFF_FFFF -> zero=1. mode=1 with a=32'hFFFF_00FF -> zero=0, lane_zero=4'b1101, first_nz=1.
- Back-to-back stream of 8 words with out_ready=1 -> 8 results in consecutive cycles, in order, in_ready=1 throughout.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready falls after 2 accepts and outputs hold. Raise out_ready -> both results are delivered in order with no loss.
- Assert reset while 2 words are in flight -> out_valid=0 and zero=1 the next cycle, and neither word appears afterwards. With ZERO_CHECK_STICKY_EN: consume one nzero result -> sticky_nz=1. Pulse sticky_clr -> sticky_nz=0.
